sap_ram: RTL and testbench
==========================

# sap_ram

Parametrised program/data memory for the SAP computer, replacing the fixed 16×8 combinational RAM. After every reset it loads a boot image from a shared package into its array with a self-timed init sequencer. It then serves registered CPU reads and writes, and lets an external program loader write words through a valid/ready port. It sits between the memory address register (MAR) and the W bus; the top level drives the bus from `data_out` when `oe` is high.

## Interface
Parameters:
- `DATA_W`, 8: word width in bits.
- `ADDR_W`, 4: address width in bits.
- `DEPTH`, 2**ADDR_W: number of words; must be ≤ 2**ADDR_W and ≥ 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ce_n`  in  1  active-low CPU read enable (bus request).
- `address`  in  ADDR_W  CPU address, taken from the MAR.
- `we`  in  1  CPU write strobe; ignored unless `ce_n` = 0.
- `wr_data`  in  DATA_W  CPU write data.
- `data_out`  out  DATA_W  registered read data.
- `oe`  out  1  high for exactly the cycles in which `data_out` is valid for the bus.
- `busy`  out  1  high while reset or the init sequence is active.
- `prog_valid`  in  1  loader has a word to write.
- `prog_addr`  in  ADDR_W  loader target address.
- `prog_data`  in  DATA_W  loader data.
- `prog_ready`  out  1  loader word accepted this cycle when high together with `prog_valid`.

## Operation
- **Reset values:** `data_out` = 0, `oe` = 0, `busy` = 1, `prog_ready` = 0. State goes to INIT with `init_addr` = 0. Array contents are not cleared by reset; they are rewritten by INIT.
- **FSM states:** INIT, RUN.
- **INIT:** each cycle writes `mem[init_addr] = boot_word(init_addr)` and increments `init_addr`. The cycle that writes `DEPTH-1` moves to RUN. While in INIT, all CPU and loader inputs are ignored, `oe` = 0 and `prog_ready` = 0.
- **Reset mid-INIT or mid-RUN:** returns to INIT at address 0 and reloads the full image, so any loader or CPU writes are overwritten.
- **RUN, CPU read** (`ce_n` = 0, `we` = 0): `data_out <= mem[address]` and `oe <= 1`.
- **RUN, CPU write** (`ce_n` = 0, `we` = 1): `mem[address] <= wr_data`. `oe <= 0`; `data_out` holds its previous value.
- **RUN, idle** (`ce_n` = 1): `oe <= 0` and `data_out <= 0`. This replaces the old tri-state 'z' output.
- **Loader port:**
  - `prog_ready` is combinational: 1 in RUN unless a CPU write is present in the same cycle.
  - Handshake = `prog_valid` & `prog_ready`; on it, `mem[prog_addr] <= prog_data`.
  - The loader must hold `prog_valid`, `prog_addr` and `prog_data` stable until accepted.
- **CPU write and loader valid in the same cycle:** CPU wins. `prog_ready` = 0 and the loader retries.
- **CPU read and accepted loader write to the same address in the same cycle:** read-first; `data_out` returns the old word.
- **Out-of-range addresses** (≥ `DEPTH`, only possible when `DEPTH` < 2**ADDR_W):
  - reads return 0;
  - writes are dropped;
  - loader writes are still acknowledged.
- **Width rule:** `boot_word` is zero-extended or truncated to `DATA_W`. Image entries beyond index 15 are 0.

## Timing
- Read latency: 1 cycle. `ce_n` sampled low at edge N gives data and `oe` valid after edge N, for one cycle per request.
- Back-to-back reads stream one word per cycle.
- Reset sampled at edge R: INIT writes occur at edges R+1 … R+DEPTH. `busy` falls after edge R+DEPTH, so RUN is first observable in the cycle after edge R+DEPTH. For the default parameters that is 16 cycles.
- Loader throughput: one word per cycle when uncontested.
- A CPU write issued at edge N is visible to a read issued at edge N+1.

## Structure
- **Package `sap_ram_pkg`:**
  - opcode constants `OP_LDA`=0, `OP_ADD`=1, `OP_SUB`=2, `OP_OUT`=E, `OP_HLT`=F;
  - state enum `ram_state_t` {INIT, RUN};
  - the 16-entry default image `BOOT_IMAGE`: 09,1A,1B,2C,E0,F0,00,00,00,01,02,03,04,04,04,04;
  - function `boot_word(addr)`.
- **Sub-module `sap_ram_init_seq`:** the INIT counter/FSM, producing `init_we`, `init_addr` and `busy`. The top holds the array, the write-port arbitration and the read register.

## Test plan
- Reset, then wait for `busy` to fall: it falls exactly 16 cycles after reset was sampled. Reads of addresses 0…15 return 09,1A,1B,2C,E0,F0,00,00,00,01,02,03,04,04,04,04, each with `oe` = 1 one cycle after its request.
- In RUN, CPU write 0x55 to address 7, read address 7 next cycle → 0x55. With `ce_n` = 1 → `oe` = 0 and `data_out` = 0.
- Loader writes 0D,1B,E0,F0 to addresses 0–3 with `prog_valid` held; `prog_ready` = 1 each cycle. Readback gives 0D,1B,E0,F0.
- CPU write 0xAA to address 3 with `prog_valid` to address 3 carrying 0x11 in the same cycle: `prog_ready` = 0 that cycle. The loader is accepted next cycle, and the final readback of address 3 = 0x11.
- Assert reset at INIT cycle 5, release: `busy` stays high 16 more cycles and address 9 reads 01. Issuing loader and CPU requests during INIT has no effect.
- With `DATA_W`=12, `ADDR_W`=5, `DEPTH`=20: address 1 reads 0x01A, address 17 reads 0x000, and a write to address 25 is dropped.

Source files
------------

// File: rtl/sap_ram_pkg.sv
// Shared definitions for the SAP program/data memory: opcodes, state type and the boot image.
package sap_ram_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic {INIT, RUN} ram_state_t;

    localparam int BOOT_LEN = 16;

    // LDA 9; ADD A; ADD B; SUB C; OUT; HLT; followed by the data words
    localparam logic [7:0] BOOT_IMAGE [BOOT_LEN] = '{
        8'h09, 8'h1A, 8'h1B, 8'h2C, 8'hE0, 8'hF0, 8'h00, 8'h00,
        8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h04, 8'h04
    };

    // Addresses past the end of the image boot as zero; callers size-cast the result
    function automatic logic [31:0] boot_word(input logic [31:0] addr);
        logic [31:0] word;
        word = '0;
        if (addr < 32'(BOOT_LEN))
            word = {24'd0, BOOT_IMAGE[addr[3:0]]};
        return word;
    endfunction

endpackage

// File: rtl/sap_ram_init_seq.sv
// Self-timed boot sequencer: walks every address once after reset, then hands the array to the CPU.
module sap_ram_init_seq
    import sap_ram_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    ram_state_t        state;
    ram_state_t        state_next;
    logic [ADDR_W-1:0] addr_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INIT;
            init_addr <= '0;
        end else begin
            state     <= state_next;
            init_addr <= addr_next;
        end
    end

    // Busy is forced high by reset itself so the port looks idle before the first edge
    always_comb begin
        state_next = state;
        addr_next  = init_addr;
        init_we    = 1'b0;
        busy       = 1'b1;
        if (!reset) begin
            case (state)
                INIT: begin
                    init_we   = 1'b1;
                    addr_next = init_addr + 1'b1;
                    if (init_addr == LAST_ADDR) begin
                        state_next = RUN;
                        addr_next  = '0;
                    end
                end
                RUN: busy = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/sap_ram.sv
// SAP memory: boot-loaded array with a registered CPU read port and a valid/ready loader write port.
module sap_ram
    import sap_ram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              we,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data_out,
    output logic              oe,
    output logic              busy,
    input  logic              prog_valid,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ready
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic [DATA_W-1:0] boot_data;
    logic              cpu_rd;
    logic              cpu_wr;
    logic              prog_fire;
    logic              addr_ok;
    logic              prog_ok;

    sap_ram_init_seq #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_init_seq (
        .clk       (clk),
        .reset     (reset),
        .init_we   (init_we),
        .init_addr (init_addr),
        .busy      (busy)
    );

    assign boot_data  = DATA_W'(boot_word(32'(init_addr)));
    assign cpu_rd     = !busy && !ce_n && !we;
    assign cpu_wr     = !busy && !ce_n && we;
    // The CPU owns the write port when it writes; the loader simply retries next cycle
    assign prog_ready = !busy && !cpu_wr;
    assign prog_fire  = prog_valid && prog_ready;
    assign addr_ok    = {1'b0, address} < DEPTH_W;
    assign prog_ok    = {1'b0, prog_addr} < DEPTH_W;

    // Out-of-range writes are dropped here, but the loader handshake still completes
    always_ff @(posedge clk) begin
        if (init_we)
            mem[init_addr] <= boot_data;
        else if (cpu_wr && addr_ok)
            mem[address] <= wr_data;
        else if (prog_fire && prog_ok)
            mem[prog_addr] <= prog_data;
    end

    // Idle cycles drive zero so the bus mux sees a clean value instead of the old tri-state
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
            oe       <= 1'b0;
        end else if (busy) begin
            oe <= 1'b0;
        end else if (cpu_rd) begin
            data_out <= addr_ok ? mem[address] : '0;
            oe       <= 1'b1;
        end else if (cpu_wr) begin
            oe <= 1'b0;
        end else begin
            data_out <= '0;
            oe       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sap_ram.sv
// Directed bench for sap_ram: default 16x8 instance plus a 20x12 instance with out-of-range addresses.
module tb_sap_ram;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] exp;
    } vec_t;

    localparam logic [7:0] BOOT_EXP [16] = '{
        8'h09, 8'h1A, 8'h1B, 8'h2C, 8'hE0, 8'hF0, 8'h00, 8'h00,
        8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h04, 8'h04
    };

    logic       clk = 1'b0;
    logic       reset;
    logic       ce_n;
    logic [3:0] address;
    logic       we;
    logic [7:0] wr_data;
    logic [7:0] data_out;
    logic       oe;
    logic       busy;
    logic       prog_valid;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic       prog_ready;

    logic        b_ce_n;
    logic [4:0]  b_address;
    logic        b_we;
    logic [11:0] b_wr_data;
    logic [11:0] b_data_out;
    logic        b_oe;
    logic        b_busy;
    logic        b_prog_valid;
    logic [4:0]  b_prog_addr;
    logic [11:0] b_prog_data;
    logic        b_prog_ready;

    int   total = 0;
    int   bad   = 0;
    int   cnt;
    vec_t boot_vecs [16];
    vec_t load_vecs [4];

    always #5 clk = ~clk;

    sap_ram dut (
        .clk        (clk),
        .reset      (reset),
        .ce_n       (ce_n),
        .address    (address),
        .we         (we),
        .wr_data    (wr_data),
        .data_out   (data_out),
        .oe         (oe),
        .busy       (busy),
        .prog_valid (prog_valid),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .prog_ready (prog_ready)
    );

    sap_ram #(
        .DATA_W (12),
        .ADDR_W (5),
        .DEPTH  (20)
    ) dut_wide (
        .clk        (clk),
        .reset      (reset),
        .ce_n       (b_ce_n),
        .address    (b_address),
        .we         (b_we),
        .wr_data    (b_wr_data),
        .data_out   (b_data_out),
        .oe         (b_oe),
        .busy       (b_busy),
        .prog_valid (b_prog_valid),
        .prog_addr  (b_prog_addr),
        .prog_data  (b_prog_data),
        .prog_ready (b_prog_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic c, input logic w, input logic [3:0] a,
                                 input logic [7:0] d, input logic pv,
                                 input logic [3:0] pa, input logic [7:0] pd);
        ce_n       = c;
        we         = w;
        address    = a;
        wr_data    = d;
        prog_valid = pv;
        prog_addr  = pa;
        prog_data  = pd;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) boot_vecs[i] = '{4'(i), BOOT_EXP[i]};
        load_vecs[0] = '{4'd0, 8'h0D};
        load_vecs[1] = '{4'd1, 8'h1B};
        load_vecs[2] = '{4'd2, 8'hE0};
        load_vecs[3] = '{4'd3, 8'hF0};

        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00);
        b_ce_n = 1'b1; b_we = 1'b0; b_address = '0; b_wr_data = '0;
        b_prog_valid = 1'b0; b_prog_addr = '0; b_prog_data = '0;

        // Reset state and boot timing
        tick();
        checkOutput("reset data_out", 32'(data_out), 32'h0);
        checkOutput("reset oe", 32'(oe), 32'h0);
        checkOutput("reset busy", 32'(busy), 32'h1);
        checkOutput("reset prog_ready", 32'(prog_ready), 32'h0);
        reset = 1'b0;
        #1;
        checkOutput("init prog_ready", 32'(prog_ready), 32'h0);
        cnt = 0;
        while (busy && cnt < 40) begin tick(); cnt++; end
        checkOutput("busy cycles", 32'(cnt), 32'd16);
        checkOutput("wide busy at 16", 32'(b_busy), 32'h1);
        while (b_busy && cnt < 60) begin tick(); cnt++; end
        checkOutput("wide busy cycles", 32'(cnt), 32'd20);

        // Boot image readback, streamed one read per cycle
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b0, boot_vecs[i].addr, 8'h00, 1'b0, 4'd0, 8'h00);
            tick();
            checkOutput($sformatf("boot read %0d", i), 32'(data_out), 32'(boot_vecs[i].exp));
            checkOutput($sformatf("boot oe %0d", i), 32'(oe), 32'h1);
        end
        applyStimulus(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00);
        tick();
        checkOutput("idle oe", 32'(oe), 32'h0);
        checkOutput("idle data_out", 32'(data_out), 32'h0);

        // CPU write then read-after-write
        applyStimulus(1'b0, 1'b0, 4'd9, 8'h00, 1'b0, 4'd0, 8'h00);
        tick();
        checkOutput("read 9", 32'(data_out), 32'h01);
        applyStimulus(1'b0, 1'b1, 4'd7, 8'h55, 1'b0, 4'd0, 8'h00);
        #1;
        checkOutput("cpu write blocks ready", 32'(prog_ready), 32'h0);
        tick();
        checkOutput("write oe", 32'(oe), 32'h0);
        checkOutput("write holds data_out", 32'(data_out), 32'h01);
        applyStimulus(1'b0, 1'b0, 4'd7, 8'h00, 1'b0, 4'd0, 8'h00);
        tick();
        checkOutput("read 7 after write", 32'(data_out), 32'h55);
        checkOutput("read 7 oe", 32'(oe), 32'h1);
        applyStimulus(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00);
        tick();
        checkOutput("idle after read oe", 32'(oe), 32'h0);
        checkOutput("idle after read data", 32'(data_out), 32'h0);

        // Loader burst, one word per cycle
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, load_vecs[i].addr, load_vecs[i].exp);
            #1;
            checkOutput($sformatf("load ready %0d", i), 32'(prog_ready), 32'h1);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, load_vecs[i].addr, 8'h00, 1'b0, 4'd0, 8'h00);
            tick();
            checkOutput($sformatf("load readback %0d", i), 32'(data_out), 32'(load_vecs[i].exp));
        end

        // CPU write and loader collide on address 3: CPU first, loader retries
        applyStimulus(1'b0, 1'b1, 4'd3, 8'hAA, 1'b1, 4'd3, 8'h11);
        #1;
        checkOutput("conflict ready", 32'(prog_ready), 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 8'h11);
        #1;
        checkOutput("retry ready", 32'(prog_ready), 32'h1);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd3, 8'h00, 1'b0, 4'd0, 8'h00);
        tick();
        checkOutput("conflict final", 32'(data_out), 32'h11);

        // Read and loader write to the same address: read returns the old word
        applyStimulus(1'b0, 1'b0, 4'd3, 8'h00, 1'b1, 4'd3, 8'h22);
        #1;
        checkOutput("read-first ready", 32'(prog_ready), 32'h1);
        tick();
        checkOutput("read-first old", 32'(data_out), 32'h11);
        applyStimulus(1'b0, 1'b0, 4'd3, 8'h00, 1'b0, 4'd0, 8'h00);
        tick();
        checkOutput("read-first new", 32'(data_out), 32'h22);

        // Wide instance: zero extension, image end, out-of-range accesses
        applyStimulus(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00);
        b_ce_n = 1'b0; b_address = 5'd1;
        tick();
        checkOutput("wide read 1", 32'(b_data_out), 32'h01A);
        b_address = 5'd17;
        tick();
        checkOutput("wide read 17", 32'(b_data_out), 32'h000);
        checkOutput("wide read 17 oe", 32'(b_oe), 32'h1);
        b_we = 1'b1; b_address = 5'd25; b_wr_data = 12'hABC;
        tick();
        b_we = 1'b0; b_prog_valid = 1'b1; b_prog_addr = 5'd30; b_prog_data = 12'h123;
        #1;
        checkOutput("wide oob loader ready", 32'(b_prog_ready), 32'h1);
        tick();
        b_prog_valid = 1'b0; b_address = 5'd25;
        tick();
        checkOutput("wide read 25", 32'(b_data_out), 32'h000);
        b_address = 5'd9;
        tick();
        checkOutput("wide read 9", 32'(b_data_out), 32'h001);
        b_address = 5'd5;
        tick();
        checkOutput("wide read 5", 32'(b_data_out), 32'h0F0);
        b_ce_n = 1'b1;

        // Reset part-way through INIT, with requests asserted during the reload
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (5) tick();
        checkOutput("mid-init busy", 32'(busy), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b1, 4'd9, 8'h66, 1'b1, 4'd9, 8'h77);
        #1;
        checkOutput("init ignores loader", 32'(prog_ready), 32'h0);
        cnt = 0;
        while (busy && cnt < 40) begin
            if (cnt == 3) checkOutput("init oe", 32'(oe), 32'h0);
            tick();
            cnt++;
        end
        checkOutput("re-init busy cycles", 32'(cnt), 32'd16);
        applyStimulus(1'b0, 1'b0, 4'd9, 8'h00, 1'b0, 4'd0, 8'h00);
        tick();
        checkOutput("re-init read 9", 32'(data_out), 32'h01);
        applyStimulus(1'b0, 1'b0, 4'd7, 8'h00, 1'b0, 4'd0, 8'h00);
        tick();
        checkOutput("re-init read 7", 32'(data_out), 32'h00);
        applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00);
        tick();
        checkOutput("re-init read 0", 32'(data_out), 32'h09);
        applyStimulus(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
